mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer.sv | 124 ++++++++++++
 tb/tb_mmio_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Function : Memory-mapped down-counting timer (CTRL/PRESET/COUNT) with irq.
// Revision : 1.0
// ============================================================================
module mmio_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nx;
    logic        pending;

    logic        hit, wr_ctrl, wr_preset;
    logic        set_pend, clr_pend_hw, en_clr;

    assign hit       = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11);
    assign wr_ctrl   = we && hit && (addr[3:2] == 2'b00);
    assign wr_preset = we && hit && (addr[3:2] == 2'b01);

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (addr[3:2])
                2'b00:   rdata = {28'h0, ctrl};
                2'b01:   rdata = preset;
                2'b10:   rdata = count;
                default: rdata = 32'h0;
            endcase
        end
    end

    // Next-state logic reads only the registered CTRL/PRESET, so a write on
    // the same edge affects the FSM one cycle later.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        set_pend    = 1'b0;
        clr_pend_hw = 1'b0;
        en_clr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl[0]) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                count_nx = preset;
                state_nx = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl[0]) begin
                    state_nx = ST_IDLE;
                end else if (count > 32'd1) begin
                    count_nx = count - 32'd1;
                end else begin
                    count_nx = 32'd0;
                    set_pend = 1'b1;
                    state_nx = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl[2:1] == 2'b01) begin
                    clr_pend_hw = 1'b1;
                    state_nx    = ST_LOAD;
                end else begin
                    en_clr   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= 32'd0;
            ctrl    <= 4'd0;
            preset  <= 32'd0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            // Software write to CTRL takes priority over the one-shot EN clear.
            if (wr_ctrl && byteen[0]) begin
                ctrl <= wdata[3:0];
            end else if (en_clr) begin
                ctrl[0] <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_preset && byteen[i]) begin
                    preset[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (set_pend) begin
                pending <= 1'b1;
            end else if (wr_ctrl || wr_preset || clr_pend_hw) begin
                pending <= 1'b0;
            end
        end
    end

    assign irq = pending & ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer
// Function : Directed self-checking bench for mmio_timer.
// Revision : 1.0
// ============================================================================
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  byteen = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int tests_run = 0;
    int fails = 0;

    mmio_timer #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Drives a write that lands on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byteen = be; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; byteen = 4'h0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1; #2; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        for (int r = 0; r < 3; r++) begin
            addr = BASE + 32'(4 * r); #1;
            tests_run++;
            if (rdata !== 32'h0) begin
                fails++; $display("FAIL reset_reg%0d: got %h expected 00000000", r, rdata);
            end
        end
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_cnt;
        pulse_reset();
        bus_write(BASE + 4, 32'd5, 4'hF);
        bus_write(BASE + 0, 32'h9, 4'hF);   // edge 0
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            addr = BASE + 8; #1;
            exp_cnt = (e < 2) ? 32'd0 : (e <= 6) ? 32'(7 - e) : 32'd0;
            tests_run++;
            if (rdata !== exp_cnt) begin
                fails++; $display("FAIL oneshot_count e%0d: got %0d expected %0d", e, rdata, exp_cnt);
            end
            tests_run++;
            if (irq !== (e >= 7)) begin
                fails++; $display("FAIL oneshot_irq e%0d: got %b expected %b", e, irq, (e >= 7));
            end
        end
        addr = BASE; #1;
        tests_run++;
        if (rdata !== 32'h8) begin fails++; $display("FAIL oneshot_ctrl: got %h expected 8", rdata); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq_hold: got %b expected 1", irq); end
        bus_write(BASE, 32'h0, 4'hF);
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_autoreload();
        logic [31:0] exp_cnt;
        int p;
        pulse_reset();
        bus_write(BASE + 4, 32'd3, 4'hF);
        bus_write(BASE + 0, 32'hB, 4'hF);   // edge 0
        @(posedge clk); #1;                 // edge 1: LOAD
        for (int e = 2; e <= 16; e++) begin
            @(posedge clk); #1;
            addr = BASE + 8; #1;
            p = (e - 2) % 5;
            exp_cnt = (p == 0) ? 32'd3 : (p == 1) ? 32'd2 : (p == 2) ? 32'd1 : 32'd0;
            tests_run++;
            if (rdata !== exp_cnt) begin
                fails++; $display("FAIL autoreload_count e%0d: got %0d expected %0d", e, rdata, exp_cnt);
            end
            tests_run++;
            if (irq !== (p == 3)) begin
                fails++; $display("FAIL autoreload_irq e%0d: got %b expected %b", e, irq, (p == 3));
            end
        end
    endtask

    task automatic test_mask();
        pulse_reset();
        bus_write(BASE + 4, 32'd2, 4'hF);
        bus_write(BASE + 0, 32'h1, 4'hF);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            tests_run++;
            if (irq !== 1'b0) begin fails++; $display("FAIL mask_irq e%0d: got %b expected 0", e, irq); end
        end
        bus_write(BASE + 0, 32'h8, 4'h1);
        addr = BASE; #1;
        tests_run++;
        if (rdata !== 32'h8) begin fails++; $display("FAIL mask_ctrl: got %h expected 8", rdata); end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL mask_irq_after_im: got %b expected 0", irq); end
    endtask

    task automatic test_byte_write();
        pulse_reset();
        bus_write(BASE + 4, 32'hAABBCCDD, 4'b0101);
        addr = BASE + 7; #1;
        tests_run++;
        if (rdata !== 32'h00BB00DD) begin fails++; $display("FAIL byte_preset: got %h expected 00bb00dd", rdata); end
        bus_write(BASE + 8, 32'hFFFFFFFF, 4'hF);
        addr = BASE + 8; #1;
        tests_run++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL byte_count_ro: got %h expected 0", rdata); end
        bus_write(BASE + 16, 32'hF, 4'hF);
        bus_write(BASE + 0, 32'hF, 4'h0);
        addr = BASE; #1;
        tests_run++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL byte_ctrl_untouched: got %h expected 0", rdata); end
        addr = BASE + 12; #1;
        tests_run++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL byte_read_12: got %h expected 0", rdata); end
        addr = BASE + 16; #1;
        tests_run++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL byte_read_16: got %h expected 0", rdata); end
    endtask

    task automatic test_reset_midcount();
        pulse_reset();
        bus_write(BASE + 4, 32'd10, 4'hF);
        bus_write(BASE + 0, 32'h9, 4'hF);
        repeat (5) @(posedge clk);
        #1; addr = BASE + 8; #1;
        tests_run++;
        if (rdata !== 32'd7) begin fails++; $display("FAIL midcount_pre: got %0d expected 7", rdata); end
        reset = 1'b1; #1;
        for (int r = 0; r < 3; r++) begin
            addr = BASE + 32'(4 * r); #0.1;
            tests_run++;
            if (rdata !== 32'h0) begin
                fails++; $display("FAIL midcount_reg%0d: got %h expected 0", r, rdata);
            end
        end
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL midcount_irq: got %b expected 0", irq); end
        #0.5; reset = 1'b0;
        addr = BASE + 8;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            tests_run++;
            if (irq !== 1'b0 || rdata !== 32'h0) begin
                fails++; $display("FAIL midcount_after e%0d: irq %b count %0d expected 0 0", e, irq, rdata);
            end
        end
    endtask

    task automatic test_same_edge_en();
        pulse_reset();
        bus_write(BASE + 4, 32'd2, 4'hF);
        bus_write(BASE + 0, 32'h9, 4'hF);   // edge 0
        repeat (3) @(posedge clk);          // edge 3: COUNT=1
        #1;
        bus_write(BASE + 0, 32'h8, 4'hF);   // edge 4: CNT->INT with EN cleared by software
        addr = BASE + 8; #1;
        tests_run++;
        if (irq !== 1'b1 || rdata !== 32'h0) begin
            fails++; $display("FAIL same_edge_int: irq %b count %0d expected 1 0", irq, rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (irq !== 1'b1 || rdata !== 32'h0) begin
            fails++; $display("FAIL same_edge_idle: irq %b count %0d expected 1 0", irq, rdata);
        end
    endtask

    task automatic test_en_wins();
        pulse_reset();
        bus_write(BASE + 4, 32'd1, 4'hF);
        bus_write(BASE + 0, 32'h9, 4'hF);   // edge 0
        repeat (3) @(posedge clk);          // edge 3: INT
        #1;
        tests_run++;
        if (irq !== 1'b1) begin fails++; $display("FAIL en_wins_int: got %b expected 1", irq); end
        bus_write(BASE + 0, 32'h9, 4'hF);   // edge 4: rewrite EN during INT
        addr = BASE; #1;
        tests_run++;
        if (rdata !== 32'h9 || irq !== 1'b0) begin
            fails++; $display("FAIL en_wins_ctrl: ctrl %h irq %b expected 9 0", rdata, irq);
        end
        repeat (3) @(posedge clk);          // edge 7: INT again
        #1;
        tests_run++;
        if (irq !== 1'b1) begin fails++; $display("FAIL en_wins_restart: got %b expected 1", irq); end
    endtask

    task automatic test_preset_zero();
        pulse_reset();
        bus_write(BASE + 0, 32'h9, 4'hF);   // edge 0, PRESET=0
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL preset0_e2: got %b expected 0", irq); end
        @(posedge clk); #1;
        tests_run++;
        if (irq !== 1'b1) begin fails++; $display("FAIL preset0_e3: got %b expected 1", irq); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_byte_write();
        test_reset_midcount();
        test_same_edge_en();
        test_en_wins();
        test_preset_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
